// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode and state types shared by the sequential ALU and its bench
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_SHL = 3'b101,
      OP_MUL = 3'b110,
      OP_NOT = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic [2:0] OPC_AND = 3'b000;
   localparam logic [2:0] OPC_OR  = 3'b001;
   localparam logic [2:0] OPC_XOR = 3'b010;
   localparam logic [2:0] OPC_ADD = 3'b011;
   localparam logic [2:0] OPC_SUB = 3'b100;
   localparam logic [2:0] OPC_SHL = 3'b101;
   localparam logic [2:0] OPC_MUL = 3'b110;
   localparam logic [2:0] OPC_NOT = 3'b111;

endpackage

// File: rtl/seq_alu_hs_mul.sv
// rtl/seq_alu_hs_mul.sv - shift-add serial multiplier, one partial product per cycle
module alu_mul_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   // done is held for one cycle after the last iteration so the top can register the result
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == CNT_LAST) begin
            busy_d = 1'b0;
         end else begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign done    = busy_q && (cnt_q == CNT_LAST);
   assign product = acc_q[WIDTH-1:0];
   assign ovf     = |acc_q[PW-1:WIDTH];

endmodule

// File: rtl/seq_alu_hs.sv
// rtl/seq_alu_hs.sv - registered 8-op ALU with valid/ready on operands and result
module seq_alu_hs
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       N,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] X,
   output logic             C,
   output logic             Z
);

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic             c_q, c_d;
   logic             z_q, z_d;

   op_e              op;
   logic [WIDTH:0]   sum, diff;
   logic             shl_big;
   logic [WIDTH-1:0] alu_x;
   logic             alu_c;
   logic             mul_start, mul_done, mul_ovf;
   logic [WIDTH-1:0] mul_x;

   assign op        = op_e'(N);
   assign mul_start = in_ready_q && in_valid && (op == OP_MUL);

   alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (mul_x),
      .ovf     (mul_ovf)
   );

   // single-cycle datapath; MUL goes through the serial unit instead
   always_comb begin
      sum     = {1'b0, A} + {1'b0, B};
      diff    = {1'b0, A} - {1'b0, B};
      shl_big = ({1'b0, B} >= (WIDTH + 1)'(WIDTH));
      alu_x   = '0;
      alu_c   = 1'b0;
      case (op)
         OP_AND: alu_x = A & B;
         OP_OR:  alu_x = A | B;
         OP_XOR: alu_x = A ^ B;
         OP_ADD: begin
            alu_x = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         OP_SUB: begin
            alu_x = diff[WIDTH-1:0];
            alu_c = diff[WIDTH];
         end
         OP_SHL: alu_x = shl_big ? '0 : (A << B);
         OP_NOT: alu_x = ~A;
         default: alu_x = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      x_d         = x_q;
      c_d         = c_q;
      z_d         = z_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               if (op == OP_MUL) begin
                  state_d = BUSY;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  x_d         = alu_x;
                  c_d         = alu_c;
                  z_d         = (alu_x == '0);
               end
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               x_d         = mul_x;
               c_d         = mul_ovf;
               z_d         = (mul_x == '0);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         x_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         c_q         <= c_d;
         z_q         <= z_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign X         = x_q;
   assign C         = c_q;
   assign Z         = z_q;

endmodule

// File: tb/tb_seq_alu_hs.sv
// tb/tb_seq_alu_hs.sv - directed vector bench for seq_alu_hs at WIDTH=4
module tb_seq_alu_hs;
   import seq_alu_pkg::*;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [WIDTH-1:0] A, B, X;
   logic [2:0]       N;
   logic             C, Z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu_hs #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .N         (N),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X         (X),
      .C         (C),
      .Z         (Z)
   );

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       n;
      logic [WIDTH-1:0] x;
      logic             c;
      logic             z;
      int               edges_after_accept;
   } vec_t;

   vec_t vecs[$];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk4(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] n, input logic [WIDTH-1:0] x, input logic c,
                          input logic z, input int lat);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.n = n;
      v.x = x; v.c = c; v.z = z; v.edges_after_accept = lat;
      vecs.push_back(v);
   endtask

   // one full transaction with out_ready held high
   task automatic run_op(input vec_t v);
      int lat;
      @(negedge clk);
      chk1({v.name, " in_ready before"}, in_ready, 1'b1);
      A = v.a; B = v.b; N = v.n; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; A = '0; B = '0; N = '0;
      lat = 0;
      while (!out_valid && lat <= 20) begin
         chk1({v.name, " in_ready busy"}, in_ready, 1'b0);
         @(negedge clk);
         lat++;
      end
      chki({v.name, " latency"}, lat, v.edges_after_accept);
      chk4({v.name, " X"}, X, v.x);
      chk1({v.name, " C"}, C, v.c);
      chk1({v.name, " Z"}, Z, v.z);
      chk1({v.name, " in_ready done"}, in_ready, 1'b0);
      @(negedge clk);
      chk1({v.name, " out_valid after"}, out_valid, 1'b0);
      chk1({v.name, " in_ready after"}, in_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; N = '0;

      add_vec("AND",      4'b0110, 4'b0101, OPC_AND, 4'b0100, 1'b0, 1'b0, 0);
      add_vec("OR",       4'b0110, 4'b0101, OPC_OR,  4'b0111, 1'b0, 1'b0, 0);
      add_vec("XOR",      4'b0110, 4'b0101, OPC_XOR, 4'b0011, 1'b0, 1'b0, 0);
      add_vec("NOT",      4'b0110, 4'b0101, OPC_NOT, 4'b1001, 1'b0, 1'b0, 0);
      add_vec("ADD",      4'b0110, 4'b0101, OPC_ADD, 4'b1011, 1'b0, 1'b0, 0);
      add_vec("ADD_C",    4'b1100, 4'b0101, OPC_ADD, 4'b0001, 1'b1, 1'b0, 0);
      add_vec("ADD_CZ",   4'b1111, 4'b0001, OPC_ADD, 4'b0000, 1'b1, 1'b1, 0);
      add_vec("SUB",      4'b0110, 4'b0101, OPC_SUB, 4'b0001, 1'b0, 1'b0, 0);
      add_vec("SUB_BRW",  4'b0101, 4'b0110, OPC_SUB, 4'b1111, 1'b1, 1'b0, 0);
      add_vec("SUB_Z",    4'b0101, 4'b0101, OPC_SUB, 4'b0000, 1'b0, 1'b1, 0);
      add_vec("SHL1",     4'b0110, 4'b0001, OPC_SHL, 4'b1100, 1'b0, 1'b0, 0);
      add_vec("SHL3",     4'b0110, 4'b0011, OPC_SHL, 4'b0000, 1'b0, 1'b1, 0);
      add_vec("SHL4",     4'b0110, 4'b0100, OPC_SHL, 4'b0000, 1'b0, 1'b1, 0);
      add_vec("MUL_6x5",  4'b0110, 4'b0101, OPC_MUL, 4'b1110, 1'b1, 1'b0, WIDTH + 1);
      add_vec("MUL_3x5",  4'b0011, 4'b0101, OPC_MUL, 4'b1111, 1'b0, 1'b0, WIDTH + 1);
      add_vec("MUL_FxF",  4'b1111, 4'b1111, OPC_MUL, 4'b0001, 1'b1, 1'b0, WIDTH + 1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("reset out_valid", out_valid, 1'b0);
      chk1("reset in_ready", in_ready, 1'b1);
      chk4("reset X", X, 4'b0000);
      chk1("reset C", C, 1'b0);
      chk1("reset Z", Z, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // stalled result with a competing operation presented
      out_ready = 1'b0;
      @(negedge clk);
      A = 4'b0110; B = 4'b0101; N = OPC_ADD; in_valid = 1'b1;
      @(negedge clk);
      chk1("stall out_valid rise", out_valid, 1'b1);
      A = 4'b1111; B = 4'b1111; N = OPC_AND;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk1("stall out_valid", out_valid, 1'b1);
         chk4("stall X", X, 4'b1011);
         chk1("stall C", C, 1'b0);
         chk1("stall Z", Z, 1'b0);
         chk1("stall in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk1("release in_ready", in_ready, 1'b1);
      chk1("release out_valid", out_valid, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk1("no stray result", out_valid, 1'b0);
      end

      // reset during the second cycle of a multiply
      A = 4'b0110; B = 4'b0101; N = OPC_MUL; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk1("mul busy in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk1("midmul rst out_valid", out_valid, 1'b0);
      chk1("midmul rst in_ready", in_ready, 1'b1);
      chk4("midmul rst X", X, 4'b0000);
      repeat (8) begin
         @(negedge clk);
         chk1("midmul discarded", out_valid, 1'b0);
      end
      begin
         vec_t v;
         v.name = "MUL_after_rst"; v.a = 4'b0010; v.b = 4'b0011; v.n = OPC_MUL;
         v.x = 4'b0110; v.c = 1'b0; v.z = 1'b0; v.edges_after_accept = WIDTH + 1;
         run_op(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu_hs.md
Name: seq_alu_hs

Overview:
- Parametrised, registered successor to the combinational 4-bit A/B/N operation selector.
- Operand width is generic, and the operation set grows to 8 codes, including a multi-cycle serial multiply.
- Operands and opcode are accepted through a valid/ready handshake; the result is held under a valid/ready handshake with carry and zero flags.
- Sits between an operand source (register file/sequencer) and a result sink that may stall.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B/N present
- in_ready  output  1  block can accept a new operation
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned (shift amount for shifts)
- N  input  3  opcode
- out_valid  output  1  X/C/Z valid
- out_ready  input  1  sink accepts result
- X  output  WIDTH  result
- C  output  1  carry/borrow/overflow flag
- Z  output  1  1 when X==0

Behaviour:
- Single clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, X=0, C=0, Z=0, counter=0.
- Opcodes (all 8 are defined):
  - 000 AND, C=0.
  - 001 OR, C=0.
  - 010 XOR, C=0.
  - 011 ADD: X=(A+B) mod 2^WIDTH, C=carry-out.
  - 100 SUB: X=(A-B) mod 2^WIDTH, C=1 iff A<B (borrow).
  - 101 SHL: X=A<<B; X=0 if B>=WIDTH; C=0.
  - 110 MUL: X=low WIDTH bits of A*B, C=1 iff high WIDTH bits nonzero.
  - 111 NOT A, C=0.
- Z=(X==0) for every opcode, registered together with X.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL only; in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1; X/C/Z held stable.
- Acceptance: A/B/N are captured on a rising edge with in_valid&&in_ready. Inputs are ignored in any other cycle.
- IDLE transitions on accept:
  - Non-MUL: go to DONE; X/C/Z are written on the same edge, so latency is 1 cycle.
  - MUL: go to BUSY; load multiplicand, multiplier and a 2*WIDTH accumulator; counter=0.
- BUSY: one shift-add iteration per cycle; counter increments. After iteration WIDTH completes, go to DONE with the result written.
  - out_valid rises WIDTH+1 edges after the accept edge: 5 for WIDTH=4.
- DONE: go to IDLE on the edge where out_ready=1. out_valid stays 1 and X/C/Z stay constant while out_ready=0, for any stall length.
- No back-to-back overlap: a new operation is accepted at the earliest on the edge after the DONE→IDLE edge. Throughput is at most 1 result per 2 cycles.
- out_ready during IDLE/BUSY is ignored. in_valid during BUSY/DONE is ignored, and the source must hold it.
- rst in any state, including mid-MUL or while stalled in DONE, returns to reset values on that edge and discards the in-flight result.
- Arithmetic is unsigned. ADD/SUB use a WIDTH+1-bit internal sum. MUL accumulates at 2*WIDTH bits.

Decomposition:
- Package seq_alu_pkg:
  - op_e enum for the 8 opcodes.
  - state_e enum {IDLE, BUSY, DONE}.
  - Opcode localparams used by the bench.
- Sub-module alu_mul_serial:
  - Shift-add multiplier with start/done.
  - Owns the counter and the 2*WIDTH accumulator.
  - Outputs the product plus an overflow bit.
- The top holds the FSM, single-cycle datapath, output registers and flags.

Test Plan:
1. WIDTH=4, A=0110, B=0101, N=000/001/010/111, out_ready=1 → X=0100/0111/0011/1001, C=0, Z=0, out_valid 1 cycle after accept.
2. ADD: A=0110, B=0101 → X=1011, C=0. ADD: A=1100, B=0101 → X=0001, C=1. SUB: A=0110, B=0101 → X=0001, C=0. SUB: A=0101, B=0110 → X=1111, C=1. SUB: A=0101, B=0101 → X=0000, Z=1.
3. MUL: A=0110, B=0101 → out_valid 5 edges after accept, X=1110, C=1 (30=0x1E). MUL: A=0011, B=0101 → X=1111, C=0. in_ready=0 throughout BUSY.
4. SHL: A=0110, B=0001 → X=1100. SHL: A=0110, B=0100 → X=0000, Z=1.
5. Stall: hold out_ready=0 for 7 cycles after an ADD → X/C/Z/out_valid constant and in_ready=0. Raise out_ready → in_ready=1 on the next cycle. A second op presented during the stall is not captured.
6. Assert rst in cycle 2 of a MUL → next cycle out_valid=0, in_ready=1, X=0. A fresh MUL of 0010×0011 then gives X=0110, C=0.
